// File: rtl/tartaruga_pkg.sv
// ============================================================================
// Module   : tartaruga_pkg
// Brief    : Shared bus types plus data-cache line, state and helper definitions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tartaruga_pkg;

  typedef logic [31:0]  bus32_t;
  typedef logic [127:0] dcache_line_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    WT_REQ    = 2'd3
  } dcache_state_t;

  localparam int unsigned DCACHE_LINE_BYTES = 16;

  // Replace one 32-bit word of a line; word 0 sits in the LSBs.
  function automatic dcache_line_t dcache_merge_word(input dcache_line_t line,
                                                     input logic [1:0]   sel,
                                                     input bus32_t       word);
    dcache_line_t res;
    res = line;
    res[{sel, 5'b0} +: 32] = word;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_line_array.sv
// ============================================================================
// Module   : dcache_line_array
// Brief    : Valid/tag/data storage; asynchronous read, synchronous write,
//            valid bits cleared by reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_line_array
  import tartaruga_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES),
  parameter int unsigned TAG_W     = 28 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output dcache_line_t     o_rd_data,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  dcache_line_t     i_wr_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  dcache_line_t         r_data [NUM_LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/new_data_cache.sv
// ============================================================================
// Module   : new_data_cache
// Brief    : Direct-mapped, write-allocate, write-through L1 data cache.
// Config   : DCACHE_RSP_ADDR_CHECK_EN - drop refill responses whose line
//            address differs from the missing line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module new_data_cache
  import tartaruga_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  bus32_t       addr_i,
  input  bus32_t       data_wr_i,
  input  logic         we_i,
  input  logic         valid_i,
  output bus32_t       data_rd_o,
  output logic         ready_o,
  output bus32_t       mem_addr_o,
  output logic         mem_req_valid_o,
  input  logic         mem_req_ready_i,
  output logic         mem_we_o,
  output dcache_line_t mem_data_wr_o,
  input  dcache_line_t mem_data_line_i,
  input  logic         mem_rsp_valid_i,
  output logic         mem_rsp_ready_o,
  input  bus32_t       mem_rsp_addr_i
);

  localparam int unsigned c_idx_w = $clog2(NUM_LINES);
  localparam int unsigned c_tag_w = 28 - c_idx_w;

  dcache_state_t r_state;
  dcache_state_t w_state_nxt;

  logic [c_idx_w-1:0] w_idx;
  logic [c_tag_w-1:0] w_tag;
  logic [1:0]         w_word;

  logic               w_arr_valid;
  logic [c_tag_w-1:0] w_arr_tag;
  dcache_line_t       w_arr_data;
  logic               w_arr_wr_en;
  dcache_line_t       w_arr_wr_data;

  logic               w_hit;
  logic               w_rsp_match;
  logic               w_capture;
  dcache_line_t       w_merged;
  dcache_line_t       r_wr_line;
  logic [27:0]        r_wr_la;
  logic               w_unused;

  assign w_idx    = addr_i[4 +: c_idx_w];
  assign w_tag    = addr_i[31 -: c_tag_w];
  assign w_word   = addr_i[3:2];
  assign w_hit    = w_arr_valid && (w_arr_tag == w_tag);
  assign w_merged = dcache_merge_word(w_arr_data, w_word, data_wr_i);

`ifdef DCACHE_RSP_ADDR_CHECK_EN
  assign w_rsp_match = (mem_rsp_addr_i[31:4] == addr_i[31:4]);
  assign w_unused    = ^{addr_i[1:0], mem_rsp_addr_i[3:0]};
`else
  assign w_rsp_match = 1'b1;
  assign w_unused    = ^{addr_i[1:0], mem_rsp_addr_i};
`endif

  dcache_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (c_idx_w),
    .TAG_W     (c_tag_w)
  ) u_line_array (
    .clk        (clk_i),
    .rst_n      (rstn_i),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_arr_valid),
    .o_rd_tag   (w_arr_tag),
    .o_rd_data  (w_arr_data),
    .i_wr_en    (w_arr_wr_en),
    .i_wr_idx   (w_idx),
    .i_wr_tag   (w_tag),
    .i_wr_data  (w_arr_wr_data)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_wr_line <= '0;
      r_wr_la   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_wr_line <= w_merged;
        r_wr_la   <= addr_i[31:4];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    ready_o         = 1'b0;
    data_rd_o       = '0;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_data_wr_o   = '0;
    mem_rsp_ready_o = 1'b0;
    w_arr_wr_en     = 1'b0;
    w_arr_wr_data   = w_merged;
    w_capture       = 1'b0;

    case (r_state)
      IDLE: begin
        if (valid_i) begin
          if (!w_hit) begin
            w_state_nxt = MISS_REQ;
          end else if (we_i) begin
            // The array takes the store now; the write-through replays the same line.
            w_arr_wr_en = 1'b1;
            w_capture   = 1'b1;
            w_state_nxt = WT_REQ;
          end else begin
            ready_o   = 1'b1;
            data_rd_o = w_arr_data[{w_word, 5'b0} +: 32];
          end
        end
      end
      MISS_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = {addr_i[31:4], 4'b0};
        if (mem_req_ready_i) begin
          w_state_nxt = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i && w_rsp_match) begin
          w_arr_wr_en   = 1'b1;
          w_arr_wr_data = mem_data_line_i;
          w_state_nxt   = IDLE;
        end
      end
      WT_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = 1'b1;
        mem_addr_o      = {r_wr_la, 4'b0};
        mem_data_wr_o   = r_wr_line;
        if (mem_req_ready_i) begin
          ready_o     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_new_data_cache.sv
// ============================================================================
// Module   : tb_new_data_cache
// Brief    : Directed and random checks of new_data_cache against a line-level
//            memory and residency model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_new_data_cache;
  import tartaruga_pkg::*;

  localparam int unsigned NUM_LINES = 16;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  bus32_t       addr_i;
  bus32_t       data_wr_i;
  logic         we_i;
  logic         valid_i;
  bus32_t       data_rd_o;
  logic         ready_o;
  bus32_t       mem_addr_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic         mem_we_o;
  dcache_line_t mem_data_wr_o;
  dcache_line_t mem_data_line_i;
  logic         mem_rsp_valid_i;
  logic         mem_rsp_ready_o;
  bus32_t       mem_rsp_addr_i;

  always #5 clk_i = ~clk_i;

  new_data_cache #(.NUM_LINES(NUM_LINES)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .addr_i          (addr_i),
    .data_wr_i       (data_wr_i),
    .we_i            (we_i),
    .valid_i         (valid_i),
    .data_rd_o       (data_rd_o),
    .ready_o         (ready_o),
    .mem_addr_o      (mem_addr_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_we_o        (mem_we_o),
    .mem_data_wr_o   (mem_data_wr_o),
    .mem_data_line_i (mem_data_line_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_ready_o (mem_rsp_ready_o),
    .mem_rsp_addr_i  (mem_rsp_addr_i)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Backing memory and which line address each set currently holds.
  logic [127:0] mem [logic [27:0]];
  logic [27:0]  res_la [NUM_LINES];
  bit           res_v  [NUM_LINES];

  logic [31:0]  last_rd;
  logic [127:0] last_wl;
  int           last_nrd;
  int           last_lat;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] get_line(input logic [27:0] la);
    if (!mem.exists(la))
      mem[la] = {la, 4'h1, ~la, 4'h2, la ^ 28'h5A5A5A5, 4'h3, la[15:0], ~la[15:0]};
    return mem[la];
  endfunction

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_ready"},     ready_o,         '0);
    chk({pfx, "_req_valid"}, mem_req_valid_o, '0);
    chk({pfx, "_we"},        mem_we_o,        '0);
    chk({pfx, "_rsp_ready"}, mem_rsp_ready_o, '0);
    chk({pfx, "_rd_data"},   data_rd_o,       '0);
    chk({pfx, "_mem_addr"},  mem_addr_o,      '0);
    chk({pfx, "_mem_wdata"}, mem_data_wr_o,   '0);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    valid_i = 1'b0; we_i = 1'b0; addr_i = '0; data_wr_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
    mem_rsp_addr_i = '0; mem_data_line_i = '0;
    for (int i = 0; i < NUM_LINES; i++) res_v[i] = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
  endtask

  // One complete access, acting as the memory; rdy_pct is the request-accept probability.
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d, input int rdy_pct);
    logic [27:0]  la, pend_la, s_we;
    logic [127:0] old, exp_wl, s_data;
    logic [31:0]  exp_rd, s_addr;
    int           idx, n_rd, n_wr, cyc, rsp_wait;
    bit           hit, done, pend, stall;
    la = a[31:4];
    idx = int'(la % NUM_LINES);
    hit = res_v[idx] && (res_la[idx] == la);
    old = get_line(la);
    exp_rd = old[32*int'(a[3:2]) +: 32];
    exp_wl = old;
    exp_wl[32*int'(a[3:2]) +: 32] = d;
    n_rd = 0; n_wr = 0; cyc = 0; rsp_wait = 0;
    done = 0; pend = 0; stall = 0; pend_la = '0;
    s_addr = '0; s_we = '0; s_data = '0;
    last_rd = '0; last_wl = '0; last_lat = -1;
    addr_i = a; we_i = w; data_wr_i = d; valid_i = 1'b1;
    while (!done && cyc < 200) begin
      mem_req_ready_i = ($urandom_range(99) < rdy_pct);
      if (pend && rsp_wait == 0) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_addr_i  = {pend_la, 4'h0};
        mem_data_line_i = get_line(pend_la);
      end else if (!pend && $urandom_range(3) == 0) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_addr_i  = $urandom();
        mem_data_line_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        mem_rsp_valid_i = 1'b0;
      end
      @(negedge clk_i);
      if (stall) begin
        chk("req_hold_addr", mem_addr_o, s_addr);
        chk("req_hold_we", mem_we_o, s_we);
        chk("req_hold_data", mem_data_wr_o, s_data);
      end
      stall  = mem_req_valid_o && !mem_req_ready_i;
      s_addr = mem_addr_o; s_we = 28'(mem_we_o); s_data = mem_data_wr_o;
      if (mem_req_valid_o && mem_req_ready_i) begin
        chk("req_addr", mem_addr_o, {la, 4'h0});
        if (mem_we_o) begin
          n_wr++;
          last_wl = mem_data_wr_o;
          chk("wr_line", mem_data_wr_o, exp_wl);
          mem[la] = exp_wl;
        end else begin
          n_rd++;
          pend = 1; pend_la = mem_addr_o[31:4];
          rsp_wait = $urandom_range(3);
        end
      end
      if (mem_rsp_valid_i && mem_rsp_ready_o) pend = 0;
      else if (pend && rsp_wait > 0) rsp_wait--;
      if (ready_o) begin
        done = 1; last_lat = cyc; last_rd = data_rd_o;
      end
      @(posedge clk_i);
      #1 cyc++;
    end
    valid_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b0;
    last_nrd = n_rd;
    chk("access_done", 128'(done), 128'(1));
    chk("rd_requests", n_rd, hit ? 0 : 1);
    chk("wr_requests", n_wr, 128'(w));
    if (!w) chk("load_data", last_rd, exp_rd);
    if (hit && !w) chk("hit_latency", last_lat, 0);
    res_v[idx] = 1'b1;
    res_la[idx] = la;
  endtask

  initial begin
    do_reset();
    @(negedge clk_i);
    chk_outputs_zero("reset");
    @(posedge clk_i); #1;

    mem[28'h0000100] = 128'h0123456789ABCDEF0123456789ABCDEF;
    mem[28'h0000200] = 128'hFEDCBA9876543210FEDCBA9876543210;
    mem[28'h0000400] = 128'hFEDCBA9876543210FEDCBA9876543210;

    access(32'h0000_1000, 1'b0, '0, 100);
    chk("cold_load_data", last_rd, 32'h89ABCDEF);
    chk("cold_load_reqs", last_nrd, 1);
    access(32'h0000_1000, 1'b0, '0, 100);
    chk("hit_load_data", last_rd, 32'h89ABCDEF);
    chk("hit_load_lat", last_lat, 0);
    access(32'h0000_2000, 1'b0, '0, 100);
    chk("replace_load_data", last_rd, 32'h76543210);
    access(32'h0000_1000, 1'b0, '0, 100);
    chk("evicted_reqs", last_nrd, 1);

    do_reset();
    access(32'h0000_4000, 1'b1, 32'h89ABCDEF, 25);
    chk("store_miss_line", last_wl, 128'hFEDCBA9876543210FEDCBA9889ABCDEF);
    access(32'h0000_4008, 1'b1, 32'h01234567, 40);
    chk("store_hit_line", last_wl, 128'hFEDCBA9801234567FEDCBA9889ABCDEF);
    chk("store_hit_reqs", last_nrd, 0);
    chk("store_hit_lat_min", 128'(last_lat >= 1), 128'(1));

    // Reset while the refill is outstanding.
    addr_i = 32'h0000_3000; we_i = 1'b0; valid_i = 1'b1;
    mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0;
    for (int k = 0; k < 20 && !mem_rsp_ready_o; k++) begin
      @(posedge clk_i); #1;
    end
    chk("reach_miss_wait", mem_rsp_ready_o, 1);
    rstn_i = 1'b0;
    #1 chk_outputs_zero("mid_reset");
    for (int i = 0; i < NUM_LINES; i++) res_v[i] = 1'b0;
    @(posedge clk_i); #1;
    valid_i = 1'b0; mem_req_ready_i = 1'b0; rstn_i = 1'b1;
    mem_rsp_valid_i = 1'b1; mem_rsp_addr_i = 32'h0000_3000;
    mem_data_line_i = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    access(32'h0000_3000, 1'b0, '0, 100);
    chk("after_reset_reqs", last_nrd, 1);

    for (int n = 0; n < 300; n++) begin
      access(32'h0001_0000 * $urandom_range(3) + ($urandom_range(NUM_LINES - 1) << 4) + $urandom_range(15),
             1'($urandom_range(1)), $urandom(), $urandom_range(100, 30));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
